// File: rtl/prbs_checker_pkg.sv
// Shared types and constants for the PRBS checker slice.
// Optional word counter enabled by PRBS_CHECK_WORD_CNT_EN.
package prbs_checker_pkg;

  localparam logic [30:0] PRBS31_POLY = 31'h10000001;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic int popcnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational parallel Fibonacci LFSR, MSB-first, one word per call.
// Feed-forward mode shifts the input bits in (self-sync descrambler).
module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter int                    DATA_WIDTH        = 8,
  parameter int                    LFSR_FEED_FORWARD = 0
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [LFSR_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] dout;
  logic                  fb;
  logic                  shin;

  // POLY[k] taps x^k (state bit k-1); x^W is the implicit MSB tap.
  always_comb begin
    s    = state_in;
    dout = '0;
    fb   = 1'b0;
    shin = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb      = s[LFSR_WIDTH-1]
              ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
      dout[i] = fb ^ data_in[i];
      shin    = (LFSR_FEED_FORWARD != 0) ? data_in[i] : dout[i];
      s       = {s[LFSR_WIDTH-2:0], shin};
    end
  end

  assign state_out = s;
  assign data_out  = dout;

endmodule

// File: rtl/prbs_err_counter.sv
// Saturating bit-error accumulator: popcount of a mask, clear wins.
// Part of the prbs_checker slice (see PRBS_CHECK_WORD_CNT_EN in top).
module prbs_err_counter
  import prbs_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_en,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PW = popcnt_width(DATA_WIDTH);

  logic [PW-1:0]        pop;
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + PW'(mask[i]);
    end
  end

  // Carry out of the widened add marks saturation.
  always_comb begin
    sum     = {1'b0, count_q} + (CNT_WIDTH + 1)'(pop);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc_en) begin
      count_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunt via descrambler, then free-run.
// Define PRBS_CHECK_WORD_CNT_EN to add the word_count output.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = PRBS31_POLY,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_ERRORS = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     clear_count,
  output logic                     locked,
  output logic                     err_valid,
  output logic [DATA_WIDTH-1:0]    err_bits,
  output logic [ERR_CNT_WIDTH-1:0] err_count
`ifdef PRBS_CHECK_WORD_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] word_count
`endif
);

  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);

  logic [0:0]            state_q, state_d;
  logic [LFSR_WIDTH-1:0] ff_state_q, ff_state_d;
  logic [LFSR_WIDTH-1:0] gen_state_q, gen_state_d;
  logic [HW-1:0]         hunt_cnt_q, hunt_cnt_d;
  logic [BW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [DATA_WIDTH-1:0] err_bits_q, err_bits_d;
  logic                  err_valid_q, err_valid_d;

  logic [LFSR_WIDTH-1:0] ff_state_nx;
  logic [DATA_WIDTH-1:0] ff_out;
  logic [LFSR_WIDTH-1:0] gen_state_nx;
  logic [DATA_WIDTH-1:0] gen_out;
  logic [DATA_WIDTH-1:0] word_err;
  logic                  cnt_inc;

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .DATA_WIDTH       (DATA_WIDTH),
    .LFSR_FEED_FORWARD(1)
  ) u_ff (
    .state_in (ff_state_q),
    .data_in  (in_data),
    .state_out(ff_state_nx),
    .data_out (ff_out)
  );

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .DATA_WIDTH       (DATA_WIDTH),
    .LFSR_FEED_FORWARD(0)
  ) u_gen (
    .state_in (gen_state_q),
    .data_in  ('0),
    .state_out(gen_state_nx),
    .data_out (gen_out)
  );

  assign word_err = in_data ^ gen_out;
  assign cnt_inc  = in_valid && (state_q == ST_LOCKED);

  always_comb begin
    state_d     = state_q;
    ff_state_d  = ff_state_q;
    gen_state_d = gen_state_q;
    hunt_cnt_d  = hunt_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_bits_d  = err_bits_q;
    err_valid_d = 1'b0;
    if (in_valid) begin
      ff_state_d = ff_state_nx;
      unique case (state_q)
        ST_HUNT: begin
          // A zero history would "predict" an all-zero line forever.
          if (ff_out == '0 && ff_state_nx != '0) begin
            if (hunt_cnt_q == HW'(LOCK_COUNT - 1)) begin
              state_d     = ST_LOCKED;
              gen_state_d = ff_state_nx;
              hunt_cnt_d  = '0;
              bad_cnt_d   = '0;
            end else begin
              hunt_cnt_d = hunt_cnt_q + HW'(1);
            end
          end else begin
            hunt_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          gen_state_d = gen_state_nx;
          err_bits_d  = word_err;
          err_valid_d = |word_err;
          if (|word_err) begin
            if (bad_cnt_q == BW'(UNLOCK_ERRORS - 1)) begin
              state_d    = ST_HUNT;
              bad_cnt_d  = '0;
              hunt_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      ff_state_q  <= '0;
      gen_state_q <= '0;
      hunt_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      err_bits_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ff_state_q  <= ff_state_d;
      gen_state_q <= gen_state_d;
      hunt_cnt_q  <= hunt_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_bits_q  <= err_bits_d;
      err_valid_q <= err_valid_d;
    end
  end

  prbs_err_counter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_en(cnt_inc),
    .mask  (word_err),
    .clear (clear_count),
    .count (err_count)
  );

`ifdef PRBS_CHECK_WORD_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clear_count) begin
      word_cnt_d = '0;
    end else if (cnt_inc && word_cnt_q != '1) begin
      word_cnt_d = word_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_count = word_cnt_q;
`endif

  assign locked    = (state_q == ST_LOCKED);
  assign err_valid = err_valid_q;
  assign err_bits  = err_bits_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker against a bit-history reference model.
// Also checks word_count when PRBS_CHECK_WORD_CNT_EN is defined.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        clear_count = 1'b0;
  logic        locked, locked4;
  logic        err_valid, err_valid4;
  logic [7:0]  err_bits, err_bits4;
  logic [31:0] err_count;
  logic [3:0]  err_count4;
`ifdef PRBS_CHECK_WORD_CNT_EN
  logic [31:0] word_count;
  logic [3:0]  word_count4;
`endif

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clear_count(clear_count),
    .locked     (locked),
    .err_valid  (err_valid),
    .err_bits   (err_bits),
    .err_count  (err_count)
`ifdef PRBS_CHECK_WORD_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  prbs_checker #(.ERR_CNT_WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clear_count(clear_count),
    .locked     (locked4),
    .err_valid  (err_valid4),
    .err_bits   (err_bits4),
    .err_count  (err_count4)
`ifdef PRBS_CHECK_WORD_CNT_EN
    ,
    .word_count (word_count4)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: raw bit histories, PRBS31 as b[n] = b[n-31] ^ b[n-28].
  bit         rx_q[$];
  bit         g_q[$];
  bit         tx_q[$];
  bit         m_locked;
  int         hunt, bad;
  logic [7:0] m_bits;
  bit         m_ev;
  longint     cnt32, cnt4, wcnt;

  task automatic model_reset();
    rx_q = {};
    g_q  = {};
    repeat (31) begin
      rx_q.push_back(1'b0);
      g_q.push_back(1'b0);
    end
    m_locked = 0; hunt = 0; bad = 0;
    m_bits = '0; m_ev = 0;
    cnt32 = 0; cnt4 = 0; wcnt = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input bit v, input bit c);
    bit         clean, nz, p;
    logic [7:0] exp_w;
    int         pop;
    m_ev = 0;
    if (v) begin
      clean = 1;
      exp_w = '0;
      for (int i = 7; i >= 0; i--) begin
        p = rx_q[0] ^ rx_q[3];
        if (p != d[i]) clean = 0;
        rx_q.push_back(d[i]);
        void'(rx_q.pop_front());
        p = g_q[0] ^ g_q[3];
        exp_w[i] = p;
        g_q.push_back(p);
        void'(g_q.pop_front());
      end
      if (!m_locked) begin
        nz = 0;
        foreach (rx_q[k]) nz |= rx_q[k];
        if (clean && nz) begin
          hunt++;
          if (hunt == 16) begin
            m_locked = 1; hunt = 0; bad = 0;
            g_q = rx_q;
          end
        end else begin
          hunt = 0;
        end
      end else begin
        m_bits = d ^ exp_w;
        m_ev   = (m_bits != 0);
        pop    = $countones(m_bits);
        if (!c) begin
          cnt32 = (cnt32 + pop > 64'hFFFFFFFF) ? 64'hFFFFFFFF : cnt32 + pop;
          cnt4  = (cnt4 + pop > 15) ? 15 : cnt4 + pop;
          wcnt++;
        end
        if (m_ev) begin
          bad++;
          if (bad == 4) begin m_locked = 0; bad = 0; hunt = 0; end
        end else begin
          bad = 0;
        end
      end
    end
    if (c) begin cnt32 = 0; cnt4 = 0; wcnt = 0; end
  endtask

  task automatic tx_seed();
    tx_q = {};
    repeat (31) tx_q.push_back(1'b1);
  endtask

  task automatic tx_word(output logic [7:0] w);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      b = tx_q[0] ^ tx_q[3];
      w[i] = b;
      tx_q.push_back(b);
      void'(tx_q.pop_front());
    end
  endtask

  task automatic cycle(input logic [7:0] d, input bit v, input bit c, input bit r);
    in_data = d; in_valid = v; clear_count = c; rst = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else model_step(d, v, c);
    check("locked", locked, m_locked);
    check("err_valid", err_valid, m_ev);
    check("err_bits", err_bits, m_bits);
    check("err_count", err_count, cnt32);
    check("locked4", locked4, m_locked);
    check("err_count4", err_count4, cnt4);
`ifdef PRBS_CHECK_WORD_CNT_EN
    check("word_count", word_count, wcnt);
    check("word_count4", word_count4, (wcnt > 15) ? 15 : wcnt);
`endif
  endtask

  // Sends n clean words (optionally with gaps); returns first word index seen locked.
  task automatic send_clean(input int n, input bit gaps, output int lock_at);
    logic [7:0] w;
    lock_at = -1;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(1) == 0) cycle(8'($urandom), 0, 0, 0);
      tx_word(w);
      cycle(w, 1, 0, 0);
      if (locked && lock_at < 0) lock_at = i + 1;
    end
  endtask

  initial begin
    logic [7:0] w;
    int         lock_at;
    bit         seen;

    cycle(8'h00, 0, 0, 1);
    cycle(8'h00, 1, 0, 1);
    check("rst_locked", locked, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_bits", err_bits, 0);
    check("rst_err_count", err_count, 0);

    // Clean stream from an all-ones seed.
    tx_seed();
    seen = 0;
    lock_at = -1;
    for (int i = 0; i < 40; i++) begin
      tx_word(w);
      cycle(w, 1, 0, 0);
      if (locked && lock_at < 0) lock_at = i + 1;
      seen |= err_valid;
    end
    check("lock_by_20", (lock_at > 0 && lock_at <= 20), 1);
    check("no_err_valid", seen, 0);
    check("clean_count", err_count, 0);

    // Single-bit error.
    send_clean(10, 0, lock_at);
    tx_word(w);
    cycle(w ^ 8'h08, 1, 0, 0);
    check("bit_err_bits", err_bits, 8'h08);
    check("bit_err_valid", err_valid, 1);
    check("bit_err_count", err_count, 1);
    check("bit_err_locked", locked, 1);
    send_clean(5, 0, lock_at);
    check("after_bit_valid", err_valid, 0);

    // Four fully corrupted words force HUNT.
    for (int i = 0; i < 4; i++) begin
      tx_word(w);
      cycle(w ^ 8'hFF, 1, 0, 0);
      if (i == 2) check("still_locked_3", locked, 1);
    end
    check("unlock_locked", locked, 0);
    check("unlock_count", err_count, 33);
    check("sat_count4", err_count4, 15);
    send_clean(30, 0, lock_at);
    check("relock_by_20", (lock_at > 0 && lock_at <= 20), 1);
    check("relock_count", err_count, 33);

    // Clear beats a same-cycle errored word.
    tx_word(w);
    cycle(w ^ 8'hFF, 1, 1, 0);
    check("clr_count", err_count, 0);
    check("clr_count4", err_count4, 0);
    check("clr_err_bits", err_bits, 8'hFF);
    check("clr_err_valid", err_valid, 1);
    cycle(8'h00, 0, 0, 0);
    check("idle_err_valid", err_valid, 0);
    send_clean(5, 0, lock_at);

    // Random gaps and random sparse errors.
    for (int i = 0; i < 200; i++) begin
      while ($urandom_range(1) == 0) cycle(8'($urandom), 0, ($urandom_range(31) == 0), 0);
      tx_word(w);
      if ($urandom_range(9) == 0) w ^= 8'($urandom);
      cycle(w, 1, 0, 0);
    end

    // All-zero line must never lock.
    cycle(8'h00, 1, 0, 1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(8'h00, 1, 0, 0);
      seen |= locked;
    end
    check("zero_no_lock", seen, 0);

    // Single-error scenario again with 50% valid gaps.
    cycle(8'h00, 0, 0, 1);
    tx_seed();
    send_clean(40, 1, lock_at);
    check("gap_lock_by_20", (lock_at > 0 && lock_at <= 20), 1);
    send_clean(10, 1, lock_at);
    tx_word(w);
    cycle(w ^ 8'h08, 1, 0, 0);
    check("gap_err_bits", err_bits, 8'h08);
    check("gap_err_count", err_count, 1);
    send_clean(10, 1, lock_at);
    check("gap_final_count", err_count, 1);
    check("gap_locked", locked, 1);

    // Reset while locked.
    tx_word(w);
    cycle(w ^ 8'h01, 1, 0, 1);
    check("midrst_locked", locked, 0);
    check("midrst_count", err_count, 0);
    check("midrst_err_valid", err_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
